sram_like_bridge: RTL and testbench
===================================

Name: sram_like_bridge

Overview:
- Converts the CPU core's single-cycle SRAM-style port into a req/addr_ok/data_ok ("SRAM-like") split-handshake bus port, so caches or an AXI bridge can sit behind the core.
- One instance serves one channel. The CPU top instantiates two: instruction and data.
- The core is stalled while a transaction is in flight, and read data is held while other pipeline stalls persist.
- A pipeline flush discards in-flight responses; a saturating stall-cycle counter supports performance analysis.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64.
- STRB_W, DATA_W/8, write-strobe width (derived).
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cpu_en  in  1  CPU access request; held stable while cpu_stall=1
- cpu_wen  in  STRB_W  byte write enables; 0 = read
- cpu_size  in  2  read size: 0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only)
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_hold  in  1  other pipeline stall sources active
- cpu_flush  in  1  exception/branch flush pulse
- cpu_rdata  out  DATA_W  read data, valid in DONE
- cpu_stall  out  1  stall request to the pipeline
- bus_req  out  1  request
- bus_wr  out  1  1=write
- bus_size  out  2  transfer size
- bus_wstrb  out  STRB_W  byte strobes
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  response/write-ack this cycle
- bus_rdata  in  DATA_W  read data, valid with data_ok
- stall_cycles  out  CNT_W  saturating count of cycles with cpu_stall=1

Behaviour:
- Reset values: state=IDLE, discard=0, rdata_q=0, stall_cycles=0; bus_req=0, cpu_stall=0.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - bus_req = cpu_en & ~cpu_flush (combinational).
  - req&addr_ok → DATA.
  - req&~addr_ok → ADDR; address, wdata and strobes are latched into request registers.
- ADDR: bus_req=1 and bus fields are driven from the request registers until addr_ok, then → DATA. bus_req must never drop before addr_ok, including on flush.
- DATA:
  - On data_ok, bus_rdata is captured into rdata_q.
  - → DONE if discard=0.
  - → IDLE and discard cleared if discard=1.
- DONE: cpu_stall=0 and cpu_rdata=rdata_q. If ~cpu_hold → IDLE next cycle; otherwise stay, holding rdata_q.
- bus_data_ok is ignored in IDLE, ADDR and DONE. The slave guarantees data_ok never arrives in the same cycle as its own addr_ok.
- bus_wr = |wen. bus_wstrb = wen.
- bus_size for writes, derived from wen: one bit set → 0; 2'b11 aligned pair → 1; 4 aligned bits → 2; all ones with DATA_W=64 → 3.
- bus_size for reads = cpu_size. Any other strobe pattern is illegal (assertion).
- cpu_stall = (cpu_en & state≠DONE) | discard.
- Minimum latency is 3 cycles: cycle 0 req+addr_ok, cycle 1 data_ok, cycle 2 DONE with cpu_stall=0.
- Flush:
  - IDLE: no request issued.
  - ADDR or DATA: discard is set; the transaction completes on the bus, its response is dropped and DONE is skipped. A write already presented is still performed.
  - DONE: → IDLE immediately, data dropped.
  - A flush arriving while discard=1 has no further effect.
- stall_cycles increments every cycle cpu_stall=1 and saturates at all-ones.
- Reset mid-transaction returns to IDLE at once. Bus-side recovery is the system's responsibility, since the bus is reset together with the bridge.

Decomposition:
- Shared package (cpu_bus_pkg): state encoding, SIZE_BYTE/HALF/WORD/DWORD constants, and the strobe-to-size function. The data-side write-path bridge reuses this function.
- Natural sub-module: sat_counter (width-parametrised saturating counter) for stall_cycles.

Test Plan:
- Read, addr_ok at cycle 0, data_ok at cycle 1 with rdata=0xDEADBEEF → cpu_rdata=0xDEADBEEF and cpu_stall=0 at cycle 2; stall_cycles=2.
- Write wen=4'b1100 to addr 0x1002, addr_ok delayed 3 cycles → bus_req held 4 cycles with stable addr 0x1002, bus_size=1, bus_wr=1.
- cpu_hold=1 for 4 cycles after data_ok → state stays DONE, cpu_rdata stable, no new bus_req.
- cpu_flush during ADDR → req held until addr_ok; data_ok response dropped; cpu_stall=1 until that data_ok; next request carries the new address.
- Force stall_cycles to all-ones minus 1 with CNT_W=4 and run a long stall → value saturates at 15.
- Assert rst during DATA → all outputs return to reset values in the same cycle; a following read completes normally.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU-to-bus definitions: bridge states, transfer sizes
// and the write-strobe helpers reused by the data-side write path.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  function automatic logic [1:0] strb_to_size(
    input logic [7:0] s
  );
    logic [1:0] sz;
    case ($countones(s))
      1:       sz = SIZE_BYTE;
      2:       sz = SIZE_HALF;
      4:       sz = SIZE_WORD;
      default: sz = SIZE_DWORD;
    endcase
    return sz;
  endfunction

  // Only naturally aligned 1/2/4/8-byte strobe groups are legal.
  function automatic logic strb_legal(
    input logic [7:0] s,
    input int         dw
  );
    logic ok;
    case (s)
      8'h01, 8'h02, 8'h04, 8'h08,
      8'h10, 8'h20, 8'h40, 8'h80,
      8'h03, 8'h0c, 8'h30, 8'hc0,
      8'h0f, 8'hf0:          ok = 1'b1;
      8'hff:                 ok = (dw == 64);
      default:               ok = 1'b0;
    endcase
    if (dw == 32 && s[7:4] != 4'h0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised up counter that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Single-cycle SRAM port to req/addr_ok/data_ok split bus bridge.
// Stalls the core per transaction and drops responses after a flush.
module sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_hold,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [CNT_W-1:0]  stall_cycles
);

  bridge_state_e state, state_nx;
  logic discard, discard_nx;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wen;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] rdata_q;

  logic              in_addr;
  logic [STRB_W-1:0] wen_sel;
  logic [1:0]        size_sel;

  // While waiting for addr_ok the bus sees the latched request.
  assign in_addr   = (state == S_ADDR);
  assign wen_sel   = in_addr ? req_wen   : cpu_wen;
  assign size_sel  = in_addr ? req_size  : cpu_size;
  assign bus_addr  = in_addr ? req_addr  : cpu_addr;
  assign bus_wdata = in_addr ? req_wdata : cpu_wdata;
  assign bus_wstrb = wen_sel;
  assign bus_wr    = |wen_sel;
  assign bus_size  = bus_wr ? strb_to_size(8'(wen_sel))
                            : size_sel;

  assign cpu_rdata = rdata_q;
  assign cpu_stall = ~rst &
                     ((cpu_en & (state != S_DONE)) | discard);

  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    bus_req    = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus_req = cpu_en & ~cpu_flush & ~rst;
        if (bus_req)
          state_nx = bus_addr_ok ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        bus_req = 1'b1;
        if (cpu_flush) discard_nx = 1'b1;
        if (bus_addr_ok) state_nx = S_DATA;
      end
      S_DATA: begin
        if (bus_data_ok) begin
          state_nx   = (discard | cpu_flush) ? S_IDLE : S_DONE;
          discard_nx = 1'b0;
        end else if (cpu_flush) begin
          discard_nx = 1'b1;
        end
      end
      S_DONE: begin
        if (cpu_flush || !cpu_hold) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      discard <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
      if (state == S_DATA && bus_data_ok)
        rdata_q <= bus_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wen   <= '0;
      req_size  <= '0;
    end else if (state == S_IDLE && bus_req) begin
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
      req_wen   <= cpu_wen;
      req_size  <= cpu_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus_req && bus_wr)
      assert (strb_legal(8'(bus_wstrb), DATA_W));
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cpu_stall),
    .q   (stall_cycles)
  );

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed and randomized transactions against a transaction-level
// model of the bridge, with a narrow stall counter to reach saturation.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic        cpu_flush;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [3:0]  stall_cycles;

  int checks = 0;
  int errors = 0;
  int stall_model = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_wen      (cpu_wen),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_flush    (cpu_flush),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int m);
    return (m > 15) ? 15 : m;
  endfunction

  function automatic logic [1:0] wsize(input logic [3:0] w);
    case (w)
      4'h3, 4'hc: return 2'd1;
      4'hf:       return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks common to every cycle in which the core is waiting.
  task automatic stall_cycle(input string tag);
    chk({tag, "_stall"}, 64'(cpu_stall), 64'd1);
    chk({tag, "_cnt"}, 64'(stall_cycles), 64'(sat(stall_model)));
    stall_model++;
  endtask

  task automatic run_txn(input logic [31:0] a,
                         input logic [3:0]  w,
                         input logic [1:0]  sz,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int          ad,
                         input int          dd,
                         input int          hd,
                         input bit          fl_done);
    logic [1:0] esz;
    esz = (w == 4'h0) ? sz : wsize(w);
    cpu_en = 1'b1; cpu_addr = a; cpu_wen = w;
    cpu_size = sz; cpu_wdata = wd;
    for (int i = 0; i <= ad; i++) begin
      bus_addr_ok = (i == ad);
      bus_data_ok = (i != ad) && $urandom_range(1, 0) == 1;
      bus_rdata = $urandom;
      #2;
      chk("req", 64'(bus_req), 64'd1);
      chk("addr", 64'(bus_addr), 64'(a));
      chk("wr", 64'(bus_wr), 64'(w != 4'h0));
      chk("wstrb", 64'(bus_wstrb), 64'(w));
      chk("size", 64'(bus_size), 64'(esz));
      if (w != 4'h0) chk("wdata", 64'(bus_wdata), 64'(wd));
      stall_cycle("addr_ph");
      cyc();
    end
    bus_addr_ok = 1'b0;
    for (int j = 0; j <= dd; j++) begin
      bus_data_ok = (j == dd);
      bus_rdata = (j == dd) ? rd : $urandom;
      #2;
      chk("data_ph_req", 64'(bus_req), 64'd0);
      stall_cycle("data_ph");
      cyc();
    end
    for (int k = 0; k <= (fl_done ? 0 : hd); k++) begin
      bus_data_ok = $urandom_range(1, 0) == 1;
      bus_rdata = $urandom;
      cpu_hold = fl_done || (k < hd);
      cpu_flush = fl_done;
      #2;
      chk("done_stall", 64'(cpu_stall), 64'd0);
      chk("done_req", 64'(bus_req), 64'd0);
      chk("rdata", 64'(cpu_rdata), 64'(rd));
      chk("done_cnt", 64'(stall_cycles), 64'(sat(stall_model)));
      cyc();
    end
    cpu_en = 1'b0; cpu_hold = 1'b0; cpu_flush = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      #2;
      chk("idle_req", 64'(bus_req), 64'd0);
      chk("idle_stall", 64'(cpu_stall), 64'd0);
      cyc();
    end
  endtask

  initial begin
    logic [3:0] wl [7];
    wl = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf};
    rst = 1'b1; cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_hold = 1'b0;
    cpu_flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    cyc(); cyc();
    chk("rst_req", 64'(bus_req), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_cnt", 64'(stall_cycles), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    cpu_en = 1'b0; rst = 1'b0;
    idle(1);

    // Minimum-latency read: stall_cycles = 2 in DONE.
    run_txn(32'h100, 4'h0, 2'd2, 32'h0, 32'hdeadbeef, 0, 0, 0, 0);
    idle(1);

    // Half write with addr_ok three cycles late.
    run_txn(32'h1002, 4'hc, 2'd0, 32'h12345678, 32'h0, 3, 0, 0, 0);

    // Hold keeps DONE for four cycles.
    run_txn(32'h2000, 4'h0, 2'd1, 32'h0, 32'hcafef00d, 1, 2, 4, 0);
    idle(2);

    // Flush in IDLE: nothing issued that cycle.
    cpu_en = 1'b1; cpu_flush = 1'b1; cpu_addr = 32'h3000;
    #2;
    chk("idle_flush_req", 64'(bus_req), 64'd0);
    stall_cycle("idle_flush");
    cyc();
    cpu_flush = 1'b0;
    run_txn(32'h3000, 4'h0, 2'd0, 32'h0, 32'h000000a5, 0, 1, 0, 0);

    // Flush in ADDR: request held, response dropped.
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2;
    cpu_addr = 32'h4000;
    for (int i = 0; i <= 3; i++) begin
      bus_addr_ok = (i == 3);
      cpu_flush = (i == 1);
      if (i == 1) cpu_addr = 32'h5000;
      #2;
      chk("fl_req", 64'(bus_req), 64'd1);
      chk("fl_addr", 64'(bus_addr), 64'h4000);
      stall_cycle("fl_addr_ph");
      cyc();
    end
    cpu_flush = 1'b0; bus_addr_ok = 1'b0;
    for (int j = 0; j <= 2; j++) begin
      bus_data_ok = (j == 2);
      bus_rdata = 32'hbad0bad0;
      #2;
      chk("fl_data_req", 64'(bus_req), 64'd0);
      stall_cycle("fl_data_ph");
      cyc();
    end
    bus_data_ok = 1'b0;
    run_txn(32'h5000, 4'h0, 2'd2, 32'h0, 32'h11223344, 0, 0, 0, 0);

    // Flush in DATA with the core gone idle: discard alone stalls.
    cpu_en = 1'b1; cpu_addr = 32'h6000; cpu_wen = 4'hf;
    cpu_wdata = 32'h55aa55aa; bus_addr_ok = 1'b1;
    #2;
    stall_cycle("dfl_issue");
    cyc();
    bus_addr_ok = 1'b0; cpu_flush = 1'b1;
    #2;
    stall_cycle("dfl_flush");
    cyc();
    cpu_flush = 1'b0; cpu_en = 1'b0;
    for (int j = 0; j <= 1; j++) begin
      bus_data_ok = (j == 1);
      #2;
      stall_cycle("dfl_discard");
      cyc();
    end
    bus_data_ok = 1'b0;
    idle(1);

    // Flush in DONE: straight back to IDLE, next request issues.
    run_txn(32'h7000, 4'h0, 2'd2, 32'h0, 32'h0badf00d, 0, 0, 0, 1);
    run_txn(32'h7004, 4'h0, 2'd2, 32'h0, 32'h76543210, 0, 0, 0, 0);

    // Long stall drives the 4-bit counter into saturation.
    run_txn(32'h8000, 4'h1, 2'd0, 32'h000000ff, 32'h0, 20, 1, 0, 0);
    chk("sat_cnt", 64'(stall_cycles), 64'd15);

    // Reset while in DATA.
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h9000;
    bus_addr_ok = 1'b1;
    #2;
    stall_cycle("rst_issue");
    cyc();
    bus_addr_ok = 1'b0; rst = 1'b1;
    #2;
    chk("mid_rst_req", 64'(bus_req), 64'd0);
    chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
    chk("mid_rst_cnt", 64'(stall_cycles), 64'd0);
    chk("mid_rst_rdata", 64'(cpu_rdata), 64'd0);
    stall_model = 0;
    cyc();
    rst = 1'b0;
    idle(1);
    run_txn(32'h9000, 4'h0, 2'd2, 32'h0, 32'h13579bdf, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] w;
      w = ($urandom_range(1, 0) == 1) ? wl[$urandom_range(6, 0)]
                                      : 4'h0;
      run_txn($urandom, w, 2'($urandom_range(2, 0)), $urandom,
              $urandom, $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom_range(3, 0), $urandom_range(5, 0) == 0);
      if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
